// File: rtl/counter_down_cascade.sv
// Loadable cascaded down-counter built from STAGES sub-counters.
// Borrow ripples upward through stages; bout allows further chaining.
module counter_down_cascade #(
  parameter int STAGE_W = 4,
  parameter int STAGES  = 2,
  parameter bit WRAP    = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [STAGE_W*STAGES-1:0]  load_val,
  input  logic                       bin,
  output logic [STAGE_W*STAGES-1:0]  q,
  output logic                       bout,
  output logic                       bout_r,
  output logic                       zero
);

  localparam int W = STAGE_W * STAGES;
  localparam logic [STAGE_W-1:0] ONE = 1;

  logic [W-1:0]      cnt_q;
  logic [W-1:0]      cnt_d;
  logic              bout_r_q;
  logic              bout_r_d;
  logic [STAGES-1:0] low_zero;
  logic              dec;
  logic              hold_sat;

  // low_zero[i]: all stages below i are zero, so a borrow reaches stage i
  for (genvar i = 0; i < STAGES; i++) begin : g_low
    if (i == 0) begin : g_first
      assign low_zero[i] = 1'b1;
    end else begin : g_rest
      assign low_zero[i] = ~|cnt_q[i*STAGE_W-1:0];
    end
  end

  assign dec      = bin & ~load;
  assign zero     = ~|cnt_q;
  assign bout     = dec & zero;
  assign hold_sat = bout & ~WRAP;

  // Next count: load beats decrement; each stage decrements when borrowed into
  always_comb begin
    cnt_d    = cnt_q;
    bout_r_d = bout;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && !hold_sat) begin
      for (int i = 0; i < STAGES; i++) begin
        if (low_zero[i]) begin
          cnt_d[i*STAGE_W +: STAGE_W] = cnt_q[i*STAGE_W +: STAGE_W] - ONE;
        end
      end
    end
  end

  // Count and registered borrow-out state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      bout_r_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      bout_r_q <= bout_r_d;
    end
  end

  assign q      = cnt_q;
  assign bout_r = bout_r_q;

endmodule

// File: tb/tb_counter_down_cascade.sv
// Scoreboard bench for counter_down_cascade: wrapping and saturating
// instances driven in parallel against an integer reference model.
module tb_counter_down_cascade;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [7:0] load_val;
  logic       bin;

  logic [7:0] q_w, q_s;
  logic       bout_w, bout_s;
  logic       boutr_w, boutr_s;
  logic       zero_w, zero_s;

  int vec = 0;
  int err = 0;

  typedef struct {
    int q_now[2];
    int bout[2];
    int zero[2];
    int q_next[2];
    int boutr_next[2];
  } exp_t;

  exp_t sb[$];

  int mq[2];

  always #5 clk = ~clk;

  counter_down_cascade #(.STAGE_W(4), .STAGES(2), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
    .bin(bin), .q(q_w), .bout(bout_w), .bout_r(boutr_w), .zero(zero_w)
  );

  counter_down_cascade #(.STAGE_W(4), .STAGES(2), .WRAP(1'b0)) dut_s (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
    .bin(bin), .q(q_s), .bout(bout_s), .bout_r(boutr_s), .zero(zero_s)
  );

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int act_q(input int k);
    return (k == 0) ? int'(q_w) : int'(q_s);
  endfunction

  // Reference: plain arithmetic on the whole 8-bit value
  task automatic step(input bit ld, input int val, input bit b);
    exp_t e;
    @(negedge clk);
    load     = ld;
    load_val = val[7:0];
    bin      = b;
    for (int k = 0; k < 2; k++) begin
      e.q_now[k] = mq[k];
      e.zero[k]  = (mq[k] == 0) ? 1 : 0;
      e.bout[k]  = (b && !ld && mq[k] == 0) ? 1 : 0;
      e.boutr_next[k] = e.bout[k];
      if (ld)
        mq[k] = val & 255;
      else if (b)
        mq[k] = (mq[k] == 0) ? ((k == 0) ? 255 : 0) : mq[k] - 1;
      e.q_next[k] = mq[k];
    end
    sb.push_back(e);
  endtask

  // Monitor: combinational outputs mid-cycle, registered ones after the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("q_pre_w", act_q(0), e.q_now[0]);
        chk("q_pre_s", act_q(1), e.q_now[1]);
        chk("bout_w", int'(bout_w), e.bout[0]);
        chk("bout_s", int'(bout_s), e.bout[1]);
        chk("zero_w", int'(zero_w), e.zero[0]);
        chk("zero_s", int'(zero_s), e.zero[1]);
        @(posedge clk);
        #1;
        chk("q_w", act_q(0), e.q_next[0]);
        chk("q_s", act_q(1), e.q_next[1]);
        chk("bout_r_w", int'(boutr_w), e.boutr_next[0]);
        chk("bout_r_s", int'(boutr_s), e.boutr_next[1]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check_reset_state();
    chk("rst_q_w", int'(q_w), 0);
    chk("rst_q_s", int'(q_s), 0);
    chk("rst_bout_r_w", int'(boutr_w), 0);
    chk("rst_bout_r_s", int'(boutr_s), 0);
    chk("rst_zero_w", int'(zero_w), 1);
    chk("rst_zero_s", int'(zero_s), 1);
  endtask

  initial begin
    int budget;
    rst_n    = 1'b0;
    load     = 1'b0;
    load_val = 8'h00;
    bin      = 1'b0;
    mq[0]    = 0;
    mq[1]    = 0;
    #23;
    check_reset_state();
    bin = 1'b1;
    #1;
    chk("rst_bout_w", int'(bout_w), 1);
    chk("rst_bout_s", int'(bout_s), 1);
    bin = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Underflow from 0: wrap vs saturate
    step(0, 0, 1);
    step(0, 0, 0);

    // 16 sparse pulses from 0xFF through the 0xF0 -> 0xEF stage borrow
    for (int p = 0; p < 16; p++) begin
      for (int z = 0; z < 5; z++) step(0, 0, 0);
      step(0, 0, 1);
    end
    step(0, 0, 0);

    // Load 5, count to zero, then underflow
    step(1, 8'h05, 0);
    for (int p = 0; p < 6; p++) step(0, 0, 1);
    step(0, 0, 0);

    // Load wins over bin at zero
    step(1, 8'h00, 0);
    step(1, 8'h3C, 1);
    step(0, 0, 0);

    // Cross-stage boundaries
    step(1, 8'h10, 0);
    step(0, 0, 1);
    step(1, 8'h01, 0);
    for (int p = 0; p < 3; p++) step(0, 0, 1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit ld;
      bit b;
      ld = ($urandom_range(7) == 0);
      b  = ($urandom_range(1) == 1);
      step(ld, int'($urandom_range(255)), b);
    end

    // Asynchronous reset between edges
    step(1, 8'h80, 0);
    step(0, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_state();
    mq[0] = 0;
    mq[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 1);
    step(0, 0, 0);

    budget = 0;
    while (sb.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    chk("drain", sb.size(), 0);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
